// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants for the ID stage: MIPS opcode/funct encodings,
// EX-stage operation/result-select codes and reset/zero helpers.
package id_fwd_stage_pkg;

  localparam logic        RstEnable  = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_LW      = 6'b100011;

  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_ADDU = 6'b100001;
  localparam logic [5:0] EXE_SUBU = 6'b100011;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRA  = 6'b000011;

  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_AND_OP   = 8'h24;
  localparam logic [7:0] EXE_OR_OP    = 8'h25;
  localparam logic [7:0] EXE_XOR_OP   = 8'h26;
  localparam logic [7:0] EXE_NOR_OP   = 8'h27;
  localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
  localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
  localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
  localparam logic [7:0] EXE_SLL_OP   = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP   = 8'h02;
  localparam logic [7:0] EXE_SRA_OP   = 8'h03;
  localparam logic [7:0] EXE_LUI_OP   = 8'h5C;
  localparam logic [7:0] EXE_LW_OP    = 8'hE3;

  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
  localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

endpackage

// File: rtl/id_fwd_mux.sv
// One operand select: immediate, hard zero for $0, youngest matching
// forward source, else register file data.
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                             i_read,
  input  logic [REG_AW-1:0]                i_addr,
  input  logic [DATA_W-1:0]                i_imm,
  input  logic [DATA_W-1:0]                i_rf_data,
  input  logic [NUM_FWD-1:0]               i_wreg,
  input  logic [NUM_FWD-1:0][REG_AW-1:0]   i_wd,
  input  logic [NUM_FWD-1:0][DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]                o_data
);

  // Walk oldest to youngest so the lowest index overwrites last and wins.
  always_comb begin
    o_data = i_rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (i_wreg[i] && (i_wd[i] == i_addr)) o_data = i_wdata[i];
    if (i_addr == '0) o_data = '0;
    if (!i_read)      o_data = i_imm;
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage with NUM_FWD-source operand forwarding, load-use stall and a
// registered ID/EX handshake. ID_PERF_CNT_EN adds stall/invalid counters.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    pc_i,
  input  logic [31:0]                    inst_i,
  output logic                           reg1_read_o,
  output logic                           reg2_read_o,
  output logic [REG_AW-1:0]              reg1_addr_o,
  output logic [REG_AW-1:0]              reg2_addr_o,
  input  logic [DATA_W-1:0]              reg1_data_i,
  input  logic [DATA_W-1:0]              reg2_data_i,
  input  logic [NUM_FWD-1:0]             fwd_wreg_i,
  input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD-1:0][DATA_W-1:0] fwd_wdata_i,
  input  logic                           fwd0_load_i,
  input  logic                           flush_i,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]                    stall_cnt_o,
  output logic [31:0]                    invalid_cnt_o,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ALUOP_W-1:0]             aluop_o,
  output logic [ALUSEL_W-1:0]            alusel_o,
  output logic [DATA_W-1:0]              reg1_o,
  output logic [DATA_W-1:0]              reg2_o,
  output logic [REG_AW-1:0]              wd_o,
  output logic                           wreg_o,
  output logic [31:0]                    pc_o,
  output logic                           inst_invalid_o
);

  logic [5:0]              w_op, w_funct;
  logic [7:0]              w_aluop;
  logic [2:0]              w_alusel;
  logic [REG_AW-1:0]       w_wd;
  logic                    w_wreg, w_inv, w_stall, w_cap;
  logic [DATA_W-1:0]       w_imm;
  logic [1:0]              w_re, w_hit;
  logic [1:0][REG_AW-1:0]  w_addr;
  logic [1:0][DATA_W-1:0]  w_rf, w_opnd;

  assign w_op    = inst_i[31:26];
  assign w_funct = inst_i[5:0];

  always_comb begin
    w_aluop  = EXE_NOP_OP;
    w_alusel = EXE_RES_NOP;
    w_wd     = REG_AW'(NOPRegAddr);
    w_wreg   = 1'b0;
    w_re     = 2'b00;
    w_imm    = '0;
    w_inv    = 1'b0;
    case (w_op)
      EXE_SPECIAL: begin
        w_wd   = REG_AW'(inst_i[15:11]);
        w_wreg = 1'b1;
        w_re   = 2'b11;
        case (w_funct)
          EXE_AND:  begin w_aluop = EXE_AND_OP;  w_alusel = EXE_RES_LOGIC; end
          EXE_OR:   begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
          EXE_XOR:  begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
          EXE_NOR:  begin w_aluop = EXE_NOR_OP;  w_alusel = EXE_RES_LOGIC; end
          EXE_ADDU: begin w_aluop = EXE_ADDU_OP; w_alusel = EXE_RES_ARITHMETIC; end
          EXE_SUBU: begin w_aluop = EXE_SUBU_OP; w_alusel = EXE_RES_ARITHMETIC; end
          EXE_SLL, EXE_SRL, EXE_SRA: begin
            w_aluop  = (w_funct == EXE_SLL) ? EXE_SLL_OP :
                       (w_funct == EXE_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
            w_alusel = EXE_RES_SHIFT;
            w_re     = 2'b10;
            w_imm    = DATA_W'(inst_i[10:6]);
          end
          default: begin
            w_wd = REG_AW'(NOPRegAddr); w_wreg = 1'b0; w_re = 2'b00; w_inv = 1'b1;
          end
        endcase
      end
      EXE_ORI, EXE_ANDI, EXE_XORI: begin
        w_aluop  = (w_op == EXE_ORI) ? EXE_OR_OP : (w_op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
        w_alusel = EXE_RES_LOGIC;
        w_wd = REG_AW'(inst_i[20:16]); w_wreg = 1'b1; w_re = 2'b01;
        w_imm = DATA_W'(inst_i[15:0]);
      end
      EXE_ADDIU, EXE_LW: begin
        w_aluop  = (w_op == EXE_LW) ? EXE_LW_OP : EXE_ADDIU_OP;
        w_alusel = (w_op == EXE_LW) ? EXE_RES_LOAD_STORE : EXE_RES_ARITHMETIC;
        w_wd = REG_AW'(inst_i[20:16]); w_wreg = 1'b1; w_re = 2'b01;
        w_imm = DATA_W'($signed(inst_i[15:0]));
      end
      EXE_LUI: begin
        w_aluop = EXE_LUI_OP; w_alusel = EXE_RES_LOGIC;
        w_wd = REG_AW'(inst_i[20:16]); w_wreg = 1'b1;
        w_imm = DATA_W'({inst_i[15:0], 16'h0});
      end
      default: w_inv = 1'b1;
    endcase
  end

  assign w_addr[0]   = REG_AW'(inst_i[25:21]);
  assign w_addr[1]   = REG_AW'(inst_i[20:16]);
  assign w_rf[0]     = reg1_data_i;
  assign w_rf[1]     = reg2_data_i;
  assign reg1_read_o = w_re[0];
  assign reg2_read_o = w_re[1];
  assign reg1_addr_o = w_addr[0];
  assign reg2_addr_o = w_addr[1];

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux (
      .i_read(w_re[gp]), .i_addr(w_addr[gp]), .i_imm(w_imm), .i_rf_data(w_rf[gp]),
      .i_wreg(fwd_wreg_i), .i_wd(fwd_wd_i), .i_wdata(fwd_wdata_i), .o_data(w_opnd[gp])
    );
    assign w_hit[gp] = w_re[gp] && (w_addr[gp] != '0) && (w_addr[gp] == fwd_wd_i[0]);
  end

  // Source 0 holding a load means its data is not there yet: wait one cycle.
  assign w_stall  = fwd0_load_i && fwd_wreg_i[0] && (|w_hit);
  assign in_ready = !flush_i && !w_stall && (!out_valid || out_ready);
  assign w_cap    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      out_valid      <= 1'b0;
      aluop_o        <= '0;
      alusel_o       <= '0;
      reg1_o         <= '0;
      reg2_o         <= '0;
      wd_o           <= '0;
      wreg_o         <= 1'b0;
      pc_o           <= ZeroWord;
      inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
      wreg_o    <= 1'b0;
    end else if (w_cap) begin
      out_valid      <= 1'b1;
      aluop_o        <= ALUOP_W'(w_aluop);
      alusel_o       <= ALUSEL_W'(w_alusel);
      reg1_o         <= w_opnd[0];
      reg2_o         <= w_opnd[1];
      wd_o           <= w_wd;
      wreg_o         <= w_wreg;
      pc_o           <= pc_i;
      inst_invalid_o <= w_inv;
    end else if (out_ready || !out_valid) begin
      out_valid <= 1'b0;
      wreg_o    <= 1'b0;
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      stall_cnt_o   <= '0;
      invalid_cnt_o <= '0;
    end else begin
      if (w_stall && in_valid && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (w_cap && w_inv && (invalid_cnt_o != '1))    invalid_cnt_o <= invalid_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed-vector bench for id_fwd_stage: decode/forward table plus
// stall, hold, flush, drain and async-reset sequences.
module tb_id_fwd_stage;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26,
                         OP_NOR = 8'h27, OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_ADDIU = 8'h56,
                         OP_SLL = 8'h7C, OP_SRA = 8'h03, OP_LUI = 8'h5C, OP_LW = 8'hE3;
  localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2, S_AR = 3'd4, S_LS = 3'd7;

  logic              clk = 1'b0, rst = 1'b0;
  logic              in_valid, in_ready, flush, fwd0_load, out_valid, out_ready;
  logic [31:0]       pc, inst, r1d, r2d;
  logic              re1, re2;
  logic [4:0]        a1, a2;
  logic [1:0]        fwreg;
  logic [1:0][4:0]   fwd;
  logic [1:0][31:0]  fdata;
  logic [7:0]        aluop;
  logic [2:0]        alusel;
  logic [31:0]       reg1, reg2, pco;
  logic [4:0]        wd;
  logic              wreg, inv;
`ifdef ID_PERF_CNT_EN
  logic [31:0]       stall_cnt, invalid_cnt;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  id_fwd_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc), .inst_i(inst),
    .reg1_read_o(re1), .reg2_read_o(re2), .reg1_addr_o(a1), .reg2_addr_o(a2),
    .reg1_data_i(r1d), .reg2_data_i(r2d), .fwd_wreg_i(fwreg), .fwd_wd_i(fwd),
    .fwd_wdata_i(fdata), .fwd0_load_i(fwd0_load), .flush_i(flush),
`ifdef ID_PERF_CNT_EN
    .stall_cnt_o(stall_cnt), .invalid_cnt_o(invalid_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop), .alusel_o(alusel),
    .reg1_o(reg1), .reg2_o(reg2), .wd_o(wd), .wreg_o(wreg), .pc_o(pco), .inst_invalid_o(inv)
  );

  typedef struct {
    logic [31:0] inst, r1, r2;
    logic [1:0] fwreg;
    logic [1:0][4:0] fwd;
    logic [1:0][31:0] fdata;
    logic load;
    logic [31:0] e_r1, e_r2;
    logic [4:0] e_wd;
    logic e_wreg;
    logic [7:0] e_op;
    logic [2:0] e_sel;
    logic e_inv;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rt(input logic [4:0] rs, rtt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rtt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, rtt,
                                     input logic [15:0] imm);
    return {op, rs, rtt, imm};
  endfunction

  task automatic clr_fwd();
    fwreg = 2'b00; fwd = '0; fdata = '0; fwd0_load = 1'b0;
  endtask

  initial begin
    in_valid = 0; flush = 0; out_ready = 1; pc = 0; inst = 0; r1d = 0; r2d = 0;
    clr_fwd();

    //              inst                          r1        r2          fwreg  fwd            fdata                 ld  e_r1        e_r2        wd  wr op        sel    inv
    vecs[0]  = '{it(6'h0D,1,3,16'h00FF),          32'h1200, 32'hDEAD,   2'b00, {5'd0,5'd0},   {32'h0,32'h0},        0, 32'h1200,   32'hFF,     3,  1, OP_OR,    S_LOG, 0};
    vecs[1]  = '{rt(1,2,4,0,6'h25),               32'h1200, 32'h22,     2'b11, {5'd1,5'd1},   {32'hB,32'hA},        0, 32'hA,      32'h22,     4,  1, OP_OR,    S_LOG, 0};
    vecs[2]  = '{rt(0,2,4,0,6'h25),               32'h99,   32'h22,     2'b11, {5'd2,5'd0},   {32'h77,32'h55},      0, 32'h0,      32'h77,     4,  1, OP_OR,    S_LOG, 0};
    vecs[3]  = '{it(6'h09,2,7,16'hFFFE),          32'h10,   32'h0,      2'b00, {5'd0,5'd0},   {32'h0,32'h0},        0, 32'h10,     32'hFFFFFFFE, 7, 1, OP_ADDIU, S_AR,  0};
    vecs[4]  = '{it(6'h0F,0,8,16'h1234),          32'h99,   32'h88,     2'b00, {5'd0,5'd0},   {32'h0,32'h0},        0, 32'h12340000, 32'h12340000, 8, 1, OP_LUI, S_LOG, 0};
    vecs[5]  = '{rt(0,3,9,4,6'h03),               32'h0,    32'h80000000, 2'b00, {5'd0,5'd0}, {32'h0,32'h0},        0, 32'h4,      32'h80000000, 9, 1, OP_SRA,  S_SH,  0};
    vecs[6]  = '{{6'h3F,26'h0123456},             32'h5,    32'h6,      2'b00, {5'd0,5'd0},   {32'h0,32'h0},        0, 32'h0,      32'h0,      0,  0, OP_NOP,   S_NOP, 1};
    vecs[7]  = '{rt(11,12,10,0,6'h23),            32'h1111, 32'h2222,   2'b10, {5'd12,5'd12}, {32'h33,32'h44},      0, 32'h1111,   32'h33,     10, 1, OP_SUBU,  S_AR,  0};
    vecs[8]  = '{it(6'h0E,2,1,16'h8001),          32'h0,    32'h0,      2'b01, {5'd0,5'd2},   {32'h0,32'h66},       0, 32'h66,     32'h8001,   1,  1, OP_XOR,   S_LOG, 0};
    vecs[9]  = '{it(6'h23,4,5,16'h8000),          32'h400,  32'h0,      2'b01, {5'd0,5'd6},   {32'h0,32'h5},        1, 32'h400,    32'hFFFF8000, 5, 1, OP_LW,   S_LS,  0};
    vecs[10] = '{rt(0,3,2,31,6'h00),              32'h0,    32'h0,      2'b10, {5'd3,5'd0},   {32'hABC,32'h0},      0, 32'h1F,     32'hABC,    2,  1, OP_SLL,   S_SH,  0};
    vecs[11] = '{rt(21,22,20,0,6'h27),            32'h1,    32'h2,      2'b00, {5'd0,5'd0},   {32'h0,32'h0},        0, 32'h1,      32'h2,      20, 1, OP_NOR,   S_LOG, 0};

    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_wreg", 32'(wreg), 0);
    chk("rst_aluop", 32'(aluop), 32'(OP_NOP));
    chk("rst_alusel", 32'(alusel), 32'(S_NOP));
    chk("rst_reg1", reg1, 0);
    chk("rst_pc", pco, 0);
    @(negedge clk); rst = 1;

    for (int i = 0; i < 12; i++) begin
      inst = vecs[i].inst; r1d = vecs[i].r1; r2d = vecs[i].r2; pc = 32'h1000 + 32'(i * 4);
      fwreg = vecs[i].fwreg; fwd = vecs[i].fwd; fdata = vecs[i].fdata; fwd0_load = vecs[i].load;
      in_valid = 1;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_reg1", i), reg1, vecs[i].e_r1);
      chk($sformatf("v%0d_reg2", i), reg2, vecs[i].e_r2);
      chk($sformatf("v%0d_wd", i), 32'(wd), 32'(vecs[i].e_wd));
      chk($sformatf("v%0d_wreg", i), 32'(wreg), 32'(vecs[i].e_wreg));
      chk($sformatf("v%0d_aluop", i), 32'(aluop), 32'(vecs[i].e_op));
      chk($sformatf("v%0d_alusel", i), 32'(alusel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_inv", i), 32'(inv), 32'(vecs[i].e_inv));
      chk($sformatf("v%0d_pc", i), pco, 32'h1000 + 32'(i * 4));
    end
`ifdef ID_PERF_CNT_EN
    chk("invalid_cnt", invalid_cnt, 1);
`endif

    // Load-use: LW to $5 sits in source 0, ADDU $6,$5,$7 must wait one cycle.
    inst = rt(5, 7, 6, 0, 6'h21); pc = 32'h2000; r1d = 32'hBAD; r2d = 32'h7;
    fwreg = 2'b01; fwd = {5'd0, 5'd5}; fdata = '0; fwd0_load = 1;
    #1;
    chk("lu_in_ready", 32'(in_ready), 0);
    chk("lu_addr1", 32'(a1), 5);
    chk("lu_read1", 32'(re1), 1);
    step();
    chk("lu_bubble_valid", 32'(out_valid), 0);
    chk("lu_bubble_wreg", 32'(wreg), 0);
    fwreg = 2'b10; fwd = {5'd5, 5'd0}; fdata = {32'h500, 32'h0}; fwd0_load = 0;
    #1;
    chk("lu_ready_after", 32'(in_ready), 1);
    step();
    chk("lu_cap_valid", 32'(out_valid), 1);
    chk("lu_cap_reg1", reg1, 32'h500);
    chk("lu_cap_reg2", reg2, 32'h7);
    chk("lu_cap_wd", 32'(wd), 6);
    chk("lu_cap_aluop", 32'(aluop), 32'(OP_ADDU));
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 1);
`endif

    // Hold: capture ANDI $12,$0,0x0F0F then back-pressure for 3 cycles.
    clr_fwd();
    inst = it(6'h0C, 0, 12, 16'h0F0F); pc = 32'h3000;
    step();
    chk("hold_cap_reg2", reg2, 32'h0F0F);
    out_ready = 0; inst = it(6'h0E, 0, 13, 16'h0001); pc = 32'h3004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 0);
      step();
      chk($sformatf("hold%0d_valid", c), 32'(out_valid), 1);
      chk($sformatf("hold%0d_wd", c), 32'(wd), 12);
      chk($sformatf("hold%0d_pc", c), pco, 32'h3000);
    end
    out_ready = 1;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    step();
    chk("release_wd", 32'(wd), 13);
    chk("release_reg2", reg2, 32'h1);

    // Flush beats capture; the instruction stays and is taken next cycle.
    inst = it(6'h0D, 0, 14, 16'h0002); pc = 32'h4000; flush = 1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    step();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_wreg", 32'(wreg), 0);
    flush = 0;
    step();
    chk("post_flush_valid", 32'(out_valid), 1);
    chk("post_flush_wd", 32'(wd), 14);
    chk("post_flush_pc", pco, 32'h4000);

    in_valid = 0;
    step();
    chk("drain_valid", 32'(out_valid), 0);

    // Async reset mid-cycle, away from any clock edge.
    inst = it(6'h0D, 1, 3, 16'h00FF); pc = 32'h5000; r1d = 32'h1200; in_valid = 1;
    step();
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_reg1", reg1, 0);
    chk("arst_reg2", reg2, 0);
    chk("arst_wd", 32'(wd), 0);
    chk("arst_pc", pco, 0);
    chk("arst_aluop", 32'(aluop), 32'(OP_NOP));
    @(negedge clk); rst = 1;
    step();
    chk("after_rst_valid", 32'(out_valid), 1);
    chk("after_rst_reg1", reg1, 32'h1200);
    chk("after_rst_reg2", reg2, 32'hFF);
    chk("after_rst_wd", 32'(wd), 3);
    chk("after_rst_pc", pco, 32'h5000);
    in_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
